// File: rtl/softmax_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : softmax_sub_sequencer
// Brief    : Buffers N scores, then streams x_i - exp_sum through one subtractor.
// Revision : 1.0
// ============================================================================
module softmax_sub_sequencer #(
   parameter int N  = 10,
   parameter int DW = 8,
   parameter int SW = 9,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          sum_valid,
   output logic          sum_ready,
   input  logic [SW-1:0] sum_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      WAIT_SUM = 2'd1,
      EMIT     = 2'd2
   } state_t;

   localparam logic [IW-1:0] c_last = IW'(N - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] count_q, count_d;
   logic [SW-1:0] sum_q, sum_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] out_data_q, out_data_d;
   logic [IW-1:0] out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d;
   logic [DW-1:0] buf_q [N];

   logic [IW-1:0] w_rd_idx;
   logic [SW-1:0] w_sub_b;
   logic [SW-1:0] w_diff;

   // The single shared subtractor: first operand pair comes from the sum
   // handshake (element 0), later ones from the element after the current one.
   always_comb begin
      w_rd_idx = '0;
      w_sub_b  = sum_data;
      if (state_q == EMIT) begin
         w_sub_b = sum_q;
         if (out_idx_q != c_last) begin
            w_rd_idx = out_idx_q + 1'b1;
         end
      end
   end

   assign w_diff = {1'b0, buf_q[w_rd_idx]} - w_sub_b;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      if (flush) begin
         state_d     = LOAD;
         count_d     = '0;
         out_valid_d = 1'b0;
         out_idx_d   = '0;
         out_last_d  = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  if (count_q == c_last) begin
                     count_d = '0;
                     state_d = WAIT_SUM;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            WAIT_SUM: begin
               if (sum_valid) begin
                  sum_d       = sum_data;
                  state_d     = EMIT;
                  out_valid_d = 1'b1;
                  out_data_d  = w_diff;
                  out_idx_d   = '0;
                  out_last_d  = 1'b0;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_d     = LOAD;
                     out_valid_d = 1'b0;
                     out_idx_d   = '0;
                     out_last_d  = 1'b0;
                  end else begin
                     out_data_d = w_diff;
                     out_idx_d  = w_rd_idx;
                     out_last_d = (w_rd_idx == c_last);
                  end
               end
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         count_q     <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (!flush && in_valid && (state_q == LOAD)) begin
         buf_q[count_q] <= in_data;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign sum_ready = (state_q == WAIT_SUM);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != LOAD) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_softmax_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_sub_sequencer
// Brief    : Directed self-checking bench for softmax_sub_sequencer.
// Revision : 1.0
// ============================================================================
module tb_softmax_sub_sequencer;

   localparam int N = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       sum_valid;
   logic       sum_ready;
   logic [8:0] sum_data;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;
   logic [3:0] out_idx;
   logic       out_last;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] vec   [N];
   logic [8:0] exp_v [N];

   softmax_sub_sequencer #(.N(N), .DW(8), .SW(9), .IW(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .sum_data  (sum_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fills the expected table from vec with a plain 9-bit wrap subtraction.
   task automatic make_exp(input logic [8:0] s);
      for (int i = 0; i < N; i++) exp_v[i] = {1'b0, vec[i]} - s;
   endtask

   task automatic load_vec();
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         chk("load_in_ready", in_ready, 1);
         chk("load_sum_ready", sum_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      chk("wait_sum_ready", sum_ready, 1);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_busy", busy, 1);
   endtask

   task automatic send_sum(input logic [8:0] s);
      int guard;
      sum_valid = 1'b1;
      sum_data  = s;
      guard     = 0;
      while (!sum_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("sum_ready_seen", sum_ready, 1);
      tick();
      sum_valid = 1'b0;
      sum_data  = 9'h0AA;
      chk("latency1_valid", out_valid, 1);
   endtask

   // Consumes results, optionally with pseudo-random backpressure.
   task automatic run_emit(input bit bp);
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      while (k < N && cyc < 300) begin
         out_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
         chk("emit_valid", out_valid, 1);
         chk("emit_in_ready", in_ready, 0);
         chk("emit_data", out_data, exp_v[k]);
         chk("emit_idx", out_idx, k);
         chk("emit_last", out_last, (k == N - 1));
         if (out_ready) k++;
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("emit_count", k, N);
      chk("done_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
      chk("done_busy", busy, 0);
   endtask

   task automatic fill_ramp(input int base);
      for (int i = 0; i < N; i++) vec[i] = 8'(base + i * 7);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      sum_valid = 1'b0;
      sum_data  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_sum_ready", sum_ready, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", in_ready, 1);

      // Ramp 1..10 with sum 5, against hand-computed results.
      for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
      exp_v = '{9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF, 9'h000,
                9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
      load_vec();
      send_sum(9'd5);
      run_emit(1'b0);

      // Extremes: no saturation, plain 9-bit wrap.
      fill_ramp(3);
      vec[0] = 8'd255;
      make_exp(9'd0);
      load_vec();
      send_sum(9'd0);
      chk("ext_x255_s0", out_data, 9'h0FF);
      run_emit(1'b0);
      vec[0] = 8'd0;
      make_exp(9'd511);
      load_vec();
      send_sum(9'd511);
      chk("ext_x0_s511", out_data, 9'h001);
      run_emit(1'b0);

      // Backpressure.
      fill_ramp(40);
      make_exp(9'd100);
      load_vec();
      send_sum(9'd100);
      run_emit(1'b1);

      // Early sum ignored during LOAD, stray scores ignored during EMIT.
      fill_ramp(9);
      make_exp(9'h003);
      sum_valid = 1'b1;
      sum_data  = 9'h0AA;
      load_vec();
      sum_valid = 1'b0;
      tick();
      chk("hold_no_capture", out_valid, 0);
      send_sum(9'h003);
      in_valid = 1'b1;
      in_data  = 8'h77;
      run_emit(1'b0);

      // Asynchronous reset in the middle of EMIT.
      fill_ramp(20);
      load_vec();
      send_sum(9'd17);
      out_ready = 1'b1;
      repeat (5) tick();
      chk("pre_rst_idx", out_idx, 5);
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);
      fill_ramp(60);
      make_exp(9'd33);
      load_vec();
      send_sum(9'd33);
      run_emit(1'b0);

      // flush in WAIT_SUM, coincident with a sum offer.
      fill_ramp(80);
      load_vec();
      flush     = 1'b1;
      sum_valid = 1'b1;
      sum_data  = 9'd1;
      tick();
      flush     = 1'b0;
      sum_valid = 1'b0;
      chk("flw_in_ready", in_ready, 1);
      chk("flw_sum_ready", sum_ready, 0);
      chk("flw_valid", out_valid, 0);
      chk("flw_busy", busy, 0);
      fill_ramp(11);
      make_exp(9'd200);
      load_vec();
      send_sum(9'd200);
      run_emit(1'b0);

      // flush coincident with the idx 6 output handshake.
      fill_ramp(5);
      load_vec();
      send_sum(9'd2);
      out_ready = 1'b1;
      repeat (6) tick();
      chk("pre_flush_idx", out_idx, 6);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      chk("fle_valid", out_valid, 0);
      chk("fle_idx", out_idx, 0);
      chk("fle_last", out_last, 0);
      chk("fle_in_ready", in_ready, 1);
      chk("fle_busy", busy, 0);
      fill_ramp(130);
      make_exp(9'd77);
      load_vec();
      send_sum(9'd77);
      run_emit(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/softmax_sub_sequencer.md
Name: softmax_sub_sequencer

Overview:
- Serial front-end and scheduler for the pseudo-softmax normalisation step.
- Collects one vector of N log-domain scores, waits for the matching exp-sum, then time-shares one 9-bit subtractor to stream each normalised value `x_i - exp_sum` to the next stage.
- Sits between the score producer / exp-sum accumulator and the exponent/output stage.
- Replaces N parallel subtractors with a single one plus buffering.

Parameters:
- N, 10, number of scores per vector (>=2).
- DW, 8, score width.
- SW, 9, exp-sum and result width (SW = DW+1).
- IW, 4, index width, ceil(log2(N)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards the current vector.
- in_valid  in  1  score available.
- in_ready  out  1  sequencer accepts a score.
- in_data  in  DW  unsigned score x_i, in index order 0..N-1.
- sum_valid  in  1  exp-sum available.
- sum_ready  out  1  sequencer accepts exp-sum.
- sum_data  in  SW  exp-sum for the buffered vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  SW  result x_i - exp_sum.
- out_idx  out  IW  index i of out_data.
- out_last  out  1  high with the result for i = N-1.
- busy  out  1  state != LOAD or count != 0.

Behaviour:
- Reset (rst_n low, async):
  - state = LOAD, count = 0, sum register = 0, buffer contents don't-care.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - in_ready = 1 after reset release; sum_ready = 0; busy = 0.
- Handshakes: transfer on valid && ready at the rising edge. All outputs are registered or decoded from state only; no combinational path from any input to any output.
- LOAD:
  - in_ready = 1.
  - Each accepted score is written to buf[count]; count increments.
  - On acceptance with count == N-1: count -> 0, state -> WAIT_SUM.
  - sum_valid is ignored in LOAD (sum_ready = 0).
- WAIT_SUM:
  - sum_ready = 1, in_ready = 0.
  - On accept: register sum_data, state -> EMIT.
  - First out_valid is asserted the cycle after the sum handshake (latency 1).
- EMIT:
  - out_data = ({1'b0, buf[idx]} - sum) mod 2^SW, a plain 9-bit wrap; negative results appear as two's-complement, with no saturation.
  - out_idx = idx; out_last = (idx == N-1).
  - out_valid stays high with out_data, out_idx and out_last held stable until out_ready.
  - On handshake with idx < N-1: the next result is presented in the following cycle, giving full throughput of 1 result/cycle under continuous out_ready.
  - On handshake with out_last: out_valid -> 0, state -> LOAD, in_ready = 1 in the next cycle.
  - There is no overlap between vectors: in_ready = 0 throughout WAIT_SUM and EMIT.
- flush (synchronous, highest priority after reset):
  - Next state LOAD, count = 0, out_valid = 0, out_last = 0, out_idx = 0.
  - A handshake coinciding with flush is discarded.
- Simultaneous events:
  - in_valid during WAIT_SUM/EMIT: held off by in_ready = 0.
  - sum_valid during LOAD: held off by sum_ready = 0.
- Reset mid-operation discards the buffered vector and the pending sum; no partial result is emitted after release.

Test Plan:
- Load 1,2,...,10, sum = 5, out_ready = 1 -> 10 consecutive results 0x1FC,0x1FD,0x1FE,0x1FF,0x000,0x001,...,0x005, with out_idx 0..9, out_last only on idx 9, first out_valid 1 cycle after the sum handshake, then in_ready = 1.
- Extremes: x0 = 255, sum = 0 -> out_data 0x0FF. Next vector with x0 = 0, sum = 511 -> 0x001. Verify 9-bit wrap and no saturation.
- Backpressure: toggle out_ready pseudo-randomly (e.g. 1 of 3 cycles) -> out_data/out_idx stable while out_valid && !out_ready; all 10 results in order, none dropped or duplicated.
- Protocol holds: sum_valid = 1 throughout LOAD with data 0x0AA, correct sum 0x003 later; in_valid = 1 during EMIT -> no early sum capture, no extra score accepted, results use 0x003.
- Reset mid-EMIT (after idx 4 accepted), rst_n low for 2 cycles -> all outputs at reset values immediately; after release in_ready = 1, busy = 0, next vector processed correctly from idx 0.
- flush asserted in WAIT_SUM, and separately coincident with the idx 6 output handshake -> LOAD next cycle, out_valid = 0, count = 0, fresh vector accepted with correct results.
